// File: rtl/fetch_mem_sequencer.sv
// Fetch PC owner and single-port SRAM sequencer: time-shares the RAM
// between instruction fetch and MEM-stage loads/stores, one delay slot.
module fetch_mem_sequencer #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter logic [15:0] NOP_INSN      = 16'h0800,
  parameter int          ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [15:0] jumpTarget,
  input  logic        stall,
  input  logic        memReq,
  input  logic        memWrite,
  input  logic [15:0] memAddr,
  input  logic [15:0] memWdata,
  output logic [15:0] memRdata,
  output logic        memDone,
  output logic [15:0] instructionOut,
  output logic [15:0] pcOut,
  output logic        fetchDone,
  output logic        pipeStall,
  output logic [15:0] ramAddr,
  output logic [15:0] ramWdata,
  input  logic [15:0] ramRdata,
  output logic        ramOe,
  output logic        ramWe
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic {FETCH, DATA} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   fetchPC;
  logic [15:0]   pendTarget;
  logic          pendJump;

  logic lastCycle;
  logic fetchFire;
  logic dataFire;
  logic takeJump;

  assign lastCycle = (cnt == LAST);
  assign fetchFire = (state == FETCH) && lastCycle && !stall;
  assign dataFire  = (state == DATA) && lastCycle;
  assign takeJump  = jump && !pendJump;
  assign pipeStall = !fetchFire;

  always_comb begin
    ramAddr  = fetchPC;
    ramWdata = '0;
    ramOe    = 1'b1;
    ramWe    = 1'b0;
    if (state == DATA) begin
      ramAddr  = memAddr;
      ramWdata = memWdata;
      ramWe    = memWrite;
      ramOe    = !memWrite;
    end
    if (rst) begin
      ramOe = 1'b0;
      ramWe = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH;
      cnt            <= '0;
      fetchPC        <= RESET_PC;
      pendJump       <= 1'b0;
      pendTarget     <= '0;
      instructionOut <= NOP_INSN;
      pcOut          <= RESET_PC;
      memRdata       <= '0;
      memDone        <= 1'b0;
      fetchDone      <= 1'b0;
    end else begin
      fetchDone <= 1'b0;
      memDone   <= 1'b0;
      if (fetchFire) begin
        instructionOut <= ramRdata;
        pcOut          <= fetchPC;
        fetchDone      <= 1'b1;
        pendJump       <= 1'b0;
        if (pendJump)
          fetchPC <= pendTarget;
        else if (jump)
          fetchPC <= jumpTarget;
        else
          fetchPC <= fetchPC + 16'd2;
        cnt <= '0;
        // memDone high means the last access was data: never grant twice
        state <= (memReq && !memDone) ? DATA : FETCH;
      end else begin
        if (takeJump) begin
          pendJump   <= 1'b1;
          pendTarget <= jumpTarget;
        end
        if (dataFire) begin
          memDone <= 1'b1;
          if (!memWrite)
            memRdata <= ramRdata;
          cnt   <= '0;
          state <= FETCH;
        end else if (!lastCycle) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_mem_sequencer.sv
// Bench for fetch_mem_sequencer: directed scenarios plus a randomized run
// scored against an event-level model of fetch order and data accesses.
module tb_fetch_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump = 1'b0;
  logic [15:0] jumpTarget = '0;
  logic        stall = 1'b0;
  logic        memReq = 1'b0;
  logic        memWrite = 1'b0;
  logic [15:0] memAddr = '0;
  logic [15:0] memWdata = '0;
  logic [15:0] memRdata;
  logic        memDone;
  logic [15:0] instructionOut;
  logic [15:0] pcOut;
  logic        fetchDone;
  logic        pipeStall;
  logic [15:0] ramAddr;
  logic [15:0] ramWdata;
  logic [15:0] ramRdata;
  logic        ramOe;
  logic        ramWe;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ramRdata = ramAddr ^ 16'hA5A5;

  fetch_mem_sequencer #(
    .RESET_PC(16'h0000),
    .NOP_INSN(16'h0800),
    .ACCESS_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .jump(jump),
    .jumpTarget(jumpTarget),
    .stall(stall),
    .memReq(memReq),
    .memWrite(memWrite),
    .memAddr(memAddr),
    .memWdata(memWdata),
    .memRdata(memRdata),
    .memDone(memDone),
    .instructionOut(instructionOut),
    .pcOut(pcOut),
    .fetchDone(fetchDone),
    .pipeStall(pipeStall),
    .ramAddr(ramAddr),
    .ramWdata(ramWdata),
    .ramRdata(ramRdata),
    .ramOe(ramOe),
    .ramWe(ramWe)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++; if (instructionOut !== 16'h0800) begin failures++; $display("FAIL reset_insn: got %h want 0800", instructionOut); end
    checks++; if (pcOut !== 16'h0000) begin failures++; $display("FAIL reset_pc: got %h want 0000", pcOut); end
    checks++; if (memRdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata: got %h want 0000", memRdata); end
    checks++; if (fetchDone !== 1'b0 || memDone !== 1'b0) begin failures++; $display("FAIL reset_pulses: got %b%b want 00", fetchDone, memDone); end
    checks++; if (ramOe !== 1'b0 || ramWe !== 1'b0) begin failures++; $display("FAIL reset_ram_en: got oe=%b we=%b want 0 0", ramOe, ramWe); end
    rst = 1'b0;
    #1;
    checks++; if (ramOe !== 1'b1 || ramAddr !== 16'h0000) begin failures++; $display("FAIL first_fetch: got oe=%b addr=%h want 1 0000", ramOe, ramAddr); end
    checks++; if (pipeStall !== 1'b1) begin failures++; $display("FAIL first_stall: got %b want 1", pipeStall); end
  endtask

  task automatic test_sequential;
    logic [15:0] expIns [3];
    expIns = '{16'hA5A5, 16'hA5A7, 16'hA5A1};
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (pipeStall !== 1'b0 || fetchDone !== 1'b0) begin failures++; $display("FAIL seq_mid%0d: got stall=%b fd=%b want 0 0", k, pipeStall, fetchDone); end
      tick;
      checks++; if (fetchDone !== 1'b1 || pipeStall !== 1'b1) begin failures++; $display("FAIL seq_done%0d: got fd=%b stall=%b want 1 1", k, fetchDone, pipeStall); end
      checks++; if (pcOut !== 16'(2 * k)) begin failures++; $display("FAIL seq_pc%0d: got %h want %h", k, pcOut, 16'(2 * k)); end
      checks++; if (instructionOut !== expIns[k]) begin failures++; $display("FAIL seq_insn%0d: got %h want %h", k, instructionOut, expIns[k]); end
    end
  endtask

  task automatic test_jump;
    jump = 1'b1;
    jumpTarget = 16'h0040;
    tick;
    jump = 1'b0;
    checks++; if (ramAddr !== 16'h0006) begin failures++; $display("FAIL jump_slot_addr: got %h want 0006", ramAddr); end
    tick;
    checks++; if (fetchDone !== 1'b1 || pcOut !== 16'h0006) begin failures++; $display("FAIL jump_slot_pc: got fd=%b pc=%h want 1 0006", fetchDone, pcOut); end
    checks++; if (ramAddr !== 16'h0040) begin failures++; $display("FAIL jump_target_addr: got %h want 0040", ramAddr); end
    tick;
    tick;
    checks++; if (fetchDone !== 1'b1 || pcOut !== 16'h0040) begin failures++; $display("FAIL jump_target_pc: got fd=%b pc=%h want 1 0040", fetchDone, pcOut); end
    tick;
    tick;
    checks++; if (pcOut !== 16'h0042) begin failures++; $display("FAIL jump_next_pc: got %h want 0042", pcOut); end
  endtask

  task automatic test_load;
    memReq = 1'b1;
    memWrite = 1'b0;
    memAddr = 16'h8000;
    tick;
    checks++; if (ramAddr !== 16'h0044 || ramOe !== 1'b1) begin failures++; $display("FAIL load_wait: got addr=%h oe=%b want 0044 1", ramAddr, ramOe); end
    tick;
    checks++; if (fetchDone !== 1'b1 || pcOut !== 16'h0044) begin failures++; $display("FAIL load_prefetch: got fd=%b pc=%h want 1 0044", fetchDone, pcOut); end
    checks++; if (ramAddr !== 16'h8000 || ramOe !== 1'b1 || ramWe !== 1'b0) begin failures++; $display("FAIL load_drive: got addr=%h oe=%b we=%b want 8000 1 0", ramAddr, ramOe, ramWe); end
    checks++; if (pipeStall !== 1'b1) begin failures++; $display("FAIL load_stall0: got %b want 1", pipeStall); end
    tick;
    checks++; if (pipeStall !== 1'b1 || memDone !== 1'b0 || ramAddr !== 16'h8000) begin failures++; $display("FAIL load_stall1: got stall=%b md=%b addr=%h want 1 0 8000", pipeStall, memDone, ramAddr); end
    tick;
    checks++; if (memDone !== 1'b1 || memRdata !== 16'h25A5) begin failures++; $display("FAIL load_done: got md=%b rdata=%h want 1 25a5", memDone, memRdata); end
    checks++; if (fetchDone !== 1'b0 || ramAddr !== 16'h0046) begin failures++; $display("FAIL load_resume: got fd=%b addr=%h want 0 0046", fetchDone, ramAddr); end
    memReq = 1'b0;
    tick;
    tick;
    checks++; if (fetchDone !== 1'b1 || pcOut !== 16'h0046) begin failures++; $display("FAIL load_after: got fd=%b pc=%h want 1 0046", fetchDone, pcOut); end
  endtask

  task automatic test_back_to_back;
    int we;
    int md;
    int fd;
    we = 0;
    md = 0;
    fd = 0;
    memReq = 1'b1;
    memWrite = 1'b1;
    memAddr = 16'h1234;
    memWdata = 16'hBEEF;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (ramWe) begin
        we++;
        checks++; if (ramAddr !== 16'h1234 || ramWdata !== 16'hBEEF || pipeStall !== 1'b1) begin failures++; $display("FAIL b2b_drive%0d: got addr=%h wd=%h stall=%b", c, ramAddr, ramWdata, pipeStall); end
      end
      if (fetchDone) fd++;
      if (memDone) md++;
      checks++; if (memRdata !== 16'h25A5) begin failures++; $display("FAIL b2b_rdata%0d: got %h want 25a5", c, memRdata); end
    end
    memReq = 1'b0;
    checks++; if (we !== 4) begin failures++; $display("FAIL b2b_we_cycles: got %0d want 4", we); end
    checks++; if (md !== 2 || fd !== 2) begin failures++; $display("FAIL b2b_counts: got md=%0d fd=%0d want 2 2", md, fd); end
    tick;
    tick;
    checks++; if (fetchDone !== 1'b1 || pcOut !== 16'h004C) begin failures++; $display("FAIL b2b_fetch: got fd=%b pc=%h want 1 004c", fetchDone, pcOut); end
    checks++; if (ramWe !== 1'b0 || ramAddr !== 16'h004E) begin failures++; $display("FAIL b2b_idle: got we=%b addr=%h want 0 004e", ramWe, ramAddr); end
  endtask

  task automatic test_stall;
    memReq = 1'b1;
    memWrite = 1'b0;
    memAddr = 16'h9000;
    tick;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (fetchDone !== 1'b0 || pcOut !== 16'h004C || ramAddr !== 16'h004E || pipeStall !== 1'b1) begin failures++; $display("FAIL stall_hold%0d: got fd=%b pc=%h addr=%h ps=%b", c, fetchDone, pcOut, ramAddr, pipeStall); end
    end
    stall = 1'b0;
    #1;
    checks++; if (pipeStall !== 1'b0) begin failures++; $display("FAIL stall_release: got %b want 0", pipeStall); end
    tick;
    checks++; if (fetchDone !== 1'b1 || pcOut !== 16'h004E || ramAddr !== 16'h9000) begin failures++; $display("FAIL stall_grant: got fd=%b pc=%h addr=%h want 1 004e 9000", fetchDone, pcOut, ramAddr); end
    tick;
    tick;
    checks++; if (memDone !== 1'b1 || memRdata !== 16'h35A5) begin failures++; $display("FAIL stall_load: got md=%b rdata=%h want 1 35a5", memDone, memRdata); end
    memReq = 1'b0;
  endtask

  task automatic test_wrap;
    jump = 1'b1;
    jumpTarget = 16'hFFFE;
    tick;
    jump = 1'b0;
    tick;
    checks++; if (pcOut !== 16'h0050) begin failures++; $display("FAIL wrap_slot: got %h want 0050", pcOut); end
    tick;
    tick;
    checks++; if (pcOut !== 16'hFFFE || instructionOut !== 16'h5A5B || ramAddr !== 16'h0000) begin failures++; $display("FAIL wrap_top: got pc=%h insn=%h addr=%h want fffe 5a5b 0000", pcOut, instructionOut, ramAddr); end
    tick;
    tick;
    checks++; if (pcOut !== 16'h0000 || instructionOut !== 16'hA5A5) begin failures++; $display("FAIL wrap_zero: got pc=%h insn=%h want 0000 a5a5", pcOut, instructionOut); end
  endtask

  task automatic test_reset_during_data;
    memReq = 1'b1;
    memWrite = 1'b1;
    memAddr = 16'h7777;
    memWdata = 16'h1111;
    tick;
    tick;
    checks++; if (fetchDone !== 1'b1 || pcOut !== 16'h0002 || ramWe !== 1'b1) begin failures++; $display("FAIL rstdata_pre: got fd=%b pc=%h we=%b want 1 0002 1", fetchDone, pcOut, ramWe); end
    rst = 1'b1;
    #1;
    checks++; if (ramWe !== 1'b0 || ramOe !== 1'b0) begin failures++; $display("FAIL rstdata_force: got we=%b oe=%b want 0 0", ramWe, ramOe); end
    tick;
    checks++; if (instructionOut !== 16'h0800 || pcOut !== 16'h0000 || memDone !== 1'b0) begin failures++; $display("FAIL rstdata_state: got insn=%h pc=%h md=%b want 0800 0000 0", instructionOut, pcOut, memDone); end
    rst = 1'b0;
    memReq = 1'b0;
    #1;
    checks++; if (ramAddr !== 16'h0000 || ramOe !== 1'b1 || ramWe !== 1'b0) begin failures++; $display("FAIL rstdata_fetch: got addr=%h oe=%b we=%b want 0000 1 0", ramAddr, ramOe, ramWe); end
    tick;
    checks++; if (memDone !== 1'b0) begin failures++; $display("FAIL rstdata_noretry: got md=%b want 0", memDone); end
    tick;
    checks++; if (fetchDone !== 1'b1 || pcOut !== 16'h0000) begin failures++; $display("FAIL rstdata_first: got fd=%b pc=%h want 1 0000", fetchDone, pcOut); end
  endtask

  // Model: fetches complete in program order; a jump makes the next
  // completing fetch the delay slot and the one after it the target.
  task automatic test_random;
    logic [15:0] expPc;
    logic [15:0] tgt;
    logic [15:0] jt;
    logic [15:0] reqAddr;
    logic [15:0] lastRd;
    logic        armed;
    logic        jumpDriven;
    logic        reqActive;
    logic        reqWrite;
    logic        prevStall;
    int          fetchSince;
    int          reqAge;
    int          nFetch;
    int          nData;
    rst = 1'b1;
    jump = 1'b0;
    stall = 1'b0;
    memReq = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    expPc = 16'h0000;
    tgt = '0;
    jt = '0;
    reqAddr = '0;
    lastRd = '0;
    armed = 1'b0;
    jumpDriven = 1'b0;
    reqActive = 1'b0;
    reqWrite = 1'b0;
    fetchSince = 1;
    reqAge = 0;
    nFetch = 0;
    nData = 0;
    prevStall = pipeStall;
    repeat (3000) begin
      tick;
      if (jumpDriven) begin
        armed = 1'b1;
        tgt = jt;
      end
      jumpDriven = 1'b0;
      jump = 1'b0;
      checks++; if (fetchDone !== !prevStall) begin failures++; $display("FAIL rnd_pipestall: got fd=%b after ps=%b", fetchDone, prevStall); end
      checks++; if (fetchDone === 1'b1 && memDone === 1'b1) begin failures++; $display("FAIL rnd_both_done: got fd=1 md=1 want not both"); end
      if (fetchDone) begin
        nFetch++;
        fetchSince++;
        checks++; if (pcOut !== expPc || instructionOut !== (expPc ^ 16'hA5A5)) begin failures++; $display("FAIL rnd_fetch: got pc=%h insn=%h want %h %h", pcOut, instructionOut, expPc, expPc ^ 16'hA5A5); end
        expPc = armed ? tgt : expPc + 16'd2;
        armed = 1'b0;
      end
      if (memDone) begin
        nData++;
        checks++; if (!reqActive || fetchSince < 1) begin failures++; $display("FAIL rnd_data_order: got req=%b fetches=%0d want 1 >=1", reqActive, fetchSince); end
        if (!reqWrite) lastRd = reqAddr ^ 16'hA5A5;
        checks++; if (memRdata !== lastRd) begin failures++; $display("FAIL rnd_rdata: got %h want %h", memRdata, lastRd); end
        reqActive = 1'b0;
        fetchSince = 0;
      end
      if (reqActive) begin
        reqAge++;
        if (reqAge > 60) begin
          checks++;
          failures++;
          $display("FAIL rnd_timeout: got no memDone after %0d cycles want <=60", reqAge);
          reqActive = 1'b0;
        end
      end
      stall = ($urandom_range(3) == 0);
      if (!armed && $urandom_range(15) == 0) begin
        jt = 16'($urandom) & 16'hFFFE;
        jumpTarget = jt;
        jump = 1'b1;
        jumpDriven = 1'b1;
      end
      if (!reqActive && !memDone && $urandom_range(5) == 0) begin
        reqActive = 1'b1;
        reqWrite = 1'($urandom_range(1));
        reqAddr = 16'($urandom);
        memWrite = reqWrite;
        memAddr = reqAddr;
        memWdata = 16'($urandom);
        reqAge = 0;
      end
      memReq = reqActive;
      #1;
      prevStall = pipeStall;
      checks++; if (ramOe === ramWe) begin failures++; $display("FAIL rnd_ram_en: got oe=%b we=%b want exactly one", ramOe, ramWe); end
      if (ramWe) begin
        checks++; if (memReq !== 1'b1 || ramAddr !== memAddr || ramWdata !== memWdata) begin failures++; $display("FAIL rnd_store_drive: got req=%b addr=%h wd=%h want 1 %h %h", memReq, ramAddr, ramWdata, memAddr, memWdata); end
      end
    end
    checks++; if (nFetch < 200 || nData < 20) begin failures++; $display("FAIL rnd_progress: got fetches=%0d data=%0d want >=200 >=20", nFetch, nData); end
    jump = 1'b0;
    stall = 1'b0;
    memReq = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_jump;
    test_load;
    test_back_to_back;
    test_stall;
    test_wrap;
    test_reset_during_data;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
